// File: rtl/cci_rd_arbiter.sv
// cci_rd_arbiter: round-robin arbiter sharing the CCI-P c0 read-request channel.
// Tags each request's mdata with the requester id, routes responses back to the
// owner and caps outstanding reads so responses never need backpressure.
// Optional statistics counters are enabled with `define CCI_RD_ARB_STATS_EN.
module cci_rd_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_W       = 58,
  parameter int unsigned TAG_W        = 8,
  parameter int unsigned MAX_INFLIGHT = 128
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]         req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]          req_tag,
  input  logic                              out_available,
  output logic                              out_en,
  output logic [ADDR_W-1:0]                 out_addr,
  output logic [15:0]                       out_mdata,
  input  logic                              resp_valid,
  input  logic [15:0]                       resp_mdata,
  input  logic [511:0]                      resp_data,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [TAG_W-1:0]                  rsp_tag,
  output logic [511:0]                      rsp_data,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
`ifdef CCI_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]             grant_count,
  output logic [31:0]                       stall_cycles
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic               out_en_q,    out_en_d;
  logic [ADDR_W-1:0]  out_addr_q,  out_addr_d;
  logic [15:0]        out_mdata_q, out_mdata_d;
  logic [ID_W-1:0]    ptr_q,       ptr_d;
  logic [CNT_W-1:0]   inflight_q,  inflight_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0]   rsp_tag_q,   rsp_tag_d;
  logic [511:0]       rsp_data_q,  rsp_data_d;

  logic               can_issue_c;
  logic               gnt_c;
  logic [ID_W-1:0]    gnt_id_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [TAG_W-1:0]   sel_tag_c;
  logic [ID_W-1:0]    resp_id_c;

  // Upper mdata pad bits are never inspected; fold them away explicitly.
  logic unused_resp_mdata;
  assign unused_resp_mdata = ^resp_mdata;

  assign can_issue_c = out_available && (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign resp_id_c   = resp_mdata[TAG_W +: ID_W];

  // First valid requester at or after the pointer, wrapping; no grant in reset.
  always_comb begin
    logic [ID_W:0] sum;
    logic          found;
    sum      = '0;
    found    = 1'b0;
    gnt_id_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found    = 1'b1;
        gnt_id_c = sum[ID_W-1:0];
      end
    end
    gnt_c     = found && can_issue_c && !reset;
    req_ready = gnt_c ? (NUM_REQ'(1) << gnt_id_c) : '0;
  end

  // Payload mux for the granted requester.
  always_comb begin
    sel_addr_c = '0;
    sel_tag_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_c == ID_W'(i)) begin
        sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
        sel_tag_c  = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Next-state for the issue stage, pointer, credit counter and response stage.
  always_comb begin
    out_en_d    = gnt_c;
    out_addr_d  = out_addr_q;
    out_mdata_d = out_mdata_q;
    ptr_d       = ptr_q;
    inflight_d  = inflight_q;
    rsp_valid_d = '0;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;

    if (gnt_c) begin
      out_addr_d  = sel_addr_c;
      out_mdata_d = 16'({gnt_id_c, sel_tag_c});
      ptr_d       = (gnt_id_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
    end

    // Simultaneous grant and response cancel; a response at zero saturates.
    if (gnt_c && !resp_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!gnt_c && resp_valid && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    if (resp_valid) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_valid_d[i] = (resp_id_c == ID_W'(i));
      end
      rsp_tag_d  = resp_mdata[TAG_W-1:0];
      rsp_data_d = resp_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_en_q    <= 1'b0;
      out_addr_q  <= '0;
      out_mdata_q <= '0;
      ptr_q       <= '0;
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      out_en_q    <= out_en_d;
      out_addr_q  <= out_addr_d;
      out_mdata_q <= out_mdata_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign out_en    = out_en_q;
  assign out_addr  = out_addr_q;
  assign out_mdata = out_mdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_data  = rsp_data_q;
  assign inflight  = inflight_q;

`ifdef CCI_RD_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] grant_count_q, grant_count_d;
  logic [31:0]           stall_cycles_q, stall_cycles_d;

  // Per-requester grant counters and cycles lost to a blocked channel.
  always_comb begin
    grant_count_d  = grant_count_q;
    stall_cycles_d = stall_cycles_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) grant_count_d[i*32 +: 32] = grant_count_q[i*32 +: 32] + 32'd1;
    end
    if ((|req_valid) && !can_issue_c) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      grant_count_q  <= grant_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign grant_count  = grant_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/cci_rd_arbiter.md
Name: cci_rd_arbiter

Overview:
- Shares the single CCI-P c0 read-request channel among NUM_REQ requesters inside afu_manager.
- Arbitrates round-robin and tags each request's mdata with the requester index, so the shared read-response stream can be steered back to its owner.
- Enforces a global in-flight read limit, so responses can always be accepted without backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_W, 58, byte-address width of each request
TAG_W, 8, requester-private tag width; must satisfy TAG_W + clog2(NUM_REQ) <= 16
MAX_INFLIGHT, 128, maximum issued-but-unanswered reads (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester read request valid
req_ready  out  NUM_REQ  per-requester grant; request accepted on valid&ready
req_addr  in  NUM_REQ*ADDR_W  packed byte addresses; slice i belongs to requester i
req_tag  in  NUM_REQ*TAG_W  packed private tags
out_available  in  1  channel may accept a request (~c0TxAlmFull)
out_en  out  1  issue read to channel
out_addr  out  ADDR_W  issued byte address
out_mdata  out  16  {zero pad, requester id, tag}; the tag occupies bits [TAG_W-1:0]
resp_valid  in  1  read response valid from channel
resp_mdata  in  16  mdata returned with the response
resp_data  in  512  cache-line data
rsp_valid  out  NUM_REQ  one-hot response strobe to the owner
rsp_tag  out  TAG_W  returned private tag
rsp_data  out  512  returned line
inflight  out  clog2(MAX_INFLIGHT+1)  current outstanding read count

Behaviour:
- Reset values: all outputs 0, round-robin pointer = 0, inflight = 0.
- Issue condition: `can_issue = out_available && (inflight < MAX_INFLIGHT)`.
- Grant logic:
  - req_ready is combinational and at most one-hot.
  - Grant goes to the first valid requester at or after the pointer, searching upward with wrap.
  - No grant is given when can_issue = 0.
  - Requesters must not make req_valid depend on req_ready.
- Issue pipeline:
  - On a grant to requester g, out_en/out_addr/out_mdata are registered and appear the next cycle (1-cycle latency).
  - out_mdata = {pad, g, tag_g}.
  - Pointer moves to (g+1) mod NUM_REQ.
  - Without a grant, out_en = 0 next cycle; out_addr and out_mdata hold their previous values.
- In-flight counter:
  - +1 on each grant, -1 on each resp_valid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_INFLIGHT; decrement at 0 is a protocol error and the counter saturates at 0.
- Response routing (registered, 1-cycle latency):
  - id = resp_mdata[TAG_W +: clog2(NUM_REQ)].
  - rsp_valid[id] = 1 for one cycle; rsp_tag = resp_mdata[TAG_W-1:0]; rsp_data = resp_data.
  - An id >= NUM_REQ is dropped (no strobe) but still decrements inflight.
- Boundary conditions:
  - out_available deasserting has effect in the same cycle (no grant). A request already registered still issues; the almost-full margin covers it.
  - A single requester holding valid continuously gets a grant every cycle when others are idle.
  - With all requesters valid, the grant order is strict rotation 0,1,2,3,0...
- Reset mid-operation:
  - Counters, pointer and output registers clear the next cycle.
  - Responses to pre-reset requests arriving after reset are routed normally; inflight stays at 0 (saturation).

Optional Feature:
- Macro: CCI_RD_ARB_STATS_EN.
- When defined:
  - Adds output `grant_count`, NUM_REQ*32 bits: one 32-bit wrapping counter per requester, incremented on each grant, cleared by reset.
  - Adds output `stall_cycles`, 32 bits: counts cycles with any req_valid high and can_issue = 0.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Single requester: requester 2 valid, addr 0x1000, tag 0x5A, out_available = 1 -> req_ready = 4'b0100; next cycle out_en = 1, out_addr = 0x1000, out_mdata = 0x025A; inflight = 1.
- Round-robin: all 4 valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; inflight = 8.
- Backpressure: out_available = 0 for 5 cycles with all valid -> req_ready = 0 and out_en = 0 for those cycles; resumes with the next requester in rotation.
- Credit limit: MAX_INFLIGHT = 4, 6 requests pending, no responses -> exactly 4 issued, req_ready = 0. One resp_valid -> one more grant the same cycle the count drops to 3.
- Response routing: resp_valid with resp_mdata = 0x0311, data = pattern P -> next cycle rsp_valid = 4'b1000, rsp_tag = 0x11, rsp_data = P; inflight decremented. Simultaneous grant and response -> inflight unchanged.
- Reset mid-traffic: reset asserted with inflight = 3 -> next cycle inflight = 0, out_en = 0, pointer = 0. A late response with mdata 0x0100 -> rsp_valid[1] pulses and inflight stays 0.
